wash_phase_timer: RTL and testbench

Phase-duration timer for the washing-machine controller. It turns the controller's level `start_*` phase requests into one-cycle `*_done` completion pulses after a programmed number of minutes per phase. A shared prescaler derives a minute tick. The block supports pause freezing, soft restart and a remaining-time readout for the display. It sits beside the controller FSM and closes its loop: the FSM's start outputs drive this block, and this block's done outputs feed back into the FSM.

---
 rtl/wash_phase_timer.sv | 141 ++++++++++++++
 tb/tb_wash_phase_timer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// Phase-duration timer for the washing-machine controller: turns level phase
// requests into one-cycle completion pulses after a programmed number of minutes.
module wash_phase_timer #(
    parameter int unsigned TICKS_PER_MIN = 32'd3000000000,
    parameter int unsigned FILL_MIN      = 2,
    parameter int unsigned WASH_MIN      = 5,
    parameter int unsigned RINSE_MIN     = 2,
    parameter int unsigned SPIN_MIN      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rst_n,
    input  logic       start_Filling,
    input  logic       start_washing,
    input  logic       start_Rinsing,
    input  logic       start_spining,
    input  logic       timer_pause,
    output logic       Filling_water_done,
    output logic       Washing_done,
    output logic       Rinsing_done,
    output logic       spining_done,
    output logic [2:0] phase,
    output logic [7:0] min_left,
    output logic       busy
);

    localparam int unsigned PW = 32;
    localparam int unsigned MW = 8;
    localparam int unsigned DW = 4;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_MIN - 1);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4
    } phase_e;

    phase_e          phase_q, phase_d, phase_sel_c;
    logic [PW-1:0]   presc_q, presc_d;
    logic [MW-1:0]   min_cnt_q, min_cnt_d;
    logic [MW-1:0]   min_left_q, min_left_d;
    logic            fired_q, fired_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   done_q, done_d;

    // Programmed duration of a phase in minutes; idle has none.
    function automatic logic [MW-1:0] dur_of(input phase_e p);
        case (p)
            PH_FILL:  dur_of = MW'(FILL_MIN);
            PH_WASH:  dur_of = MW'(WASH_MIN);
            PH_RINSE: dur_of = MW'(RINSE_MIN);
            PH_SPIN:  dur_of = MW'(SPIN_MIN);
            default:  dur_of = '0;
        endcase
    endfunction

    // Fixed priority so overlapping requests resolve to the later phase.
    always_comb begin
        phase_sel_c = PH_IDLE;
        if (start_spining) begin
            phase_sel_c = PH_SPIN;
        end else if (start_Rinsing) begin
            phase_sel_c = PH_RINSE;
        end else if (start_washing) begin
            phase_sel_c = PH_WASH;
        end else if (start_Filling) begin
            phase_sel_c = PH_FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= PH_IDLE;
            presc_q    <= '0;
            min_cnt_q  <= '0;
            min_left_q <= '0;
            fired_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= '0;
        end else begin
            phase_q    <= phase_d;
            presc_q    <= presc_d;
            min_cnt_q  <= min_cnt_d;
            min_left_q <= min_left_d;
            fired_q    <= fired_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Phase change beats soft clear, which beats pause and counting.
    always_comb begin
        phase_d   = phase_q;
        presc_d   = presc_q;
        min_cnt_d = min_cnt_q;
        fired_d   = fired_q;
        done_d    = '0;

        if (phase_sel_c != phase_q) begin
            phase_d   = phase_sel_c;
            presc_d   = '0;
            min_cnt_d = '0;
            fired_d   = 1'b0;
        end else if (!soft_rst_n) begin
            presc_d   = '0;
            min_cnt_d = '0;
            fired_d   = 1'b0;
        end else if (phase_q != PH_IDLE && !timer_pause && !fired_q) begin
            if (presc_q == TICK_LAST) begin
                presc_d   = '0;
                min_cnt_d = min_cnt_q + MW'(1);
                if (min_cnt_d == dur_of(phase_q)) begin
                    fired_d = 1'b1;
                    case (phase_q)
                        PH_FILL:  done_d = DW'(4'b0001);
                        PH_WASH:  done_d = DW'(4'b0010);
                        PH_RINSE: done_d = DW'(4'b0100);
                        PH_SPIN:  done_d = DW'(4'b1000);
                        default:  done_d = '0;
                    endcase
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        min_left_d = dur_of(phase_d) - min_cnt_d;
        busy_d     = (phase_d != PH_IDLE);
    end

    assign phase              = phase_q;
    assign min_left           = min_left_q;
    assign busy               = busy_q;
    assign Filling_water_done = done_q[0];
    assign Washing_done       = done_q[1];
    assign Rinsing_done       = done_q[2];
    assign spining_done       = done_q[3];

endmodule

// File: tb/tb_wash_phase_timer.sv
// Bench for wash_phase_timer: directed scenarios plus random traffic, all
// checked every cycle against an elapsed-cycle reference model.
module tb_wash_phase_timer;

    localparam int unsigned T   = 4;
    localparam int unsigned FM  = 2;
    localparam int unsigned WM  = 3;
    localparam int unsigned RM  = 2;
    localparam int unsigned SM  = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_rst_n;
    logic       start_Filling, start_washing, start_Rinsing, start_spining;
    logic       timer_pause;
    logic       Filling_water_done, Washing_done, Rinsing_done, spining_done;
    logic [2:0] phase;
    logic [7:0] min_left;
    logic       busy;

    always #5 clk = ~clk;

    wash_phase_timer #(
        .TICKS_PER_MIN(T), .FILL_MIN(FM), .WASH_MIN(WM), .RINSE_MIN(RM), .SPIN_MIN(SM)
    ) dut (
        .clk(clk), .rst(rst), .soft_rst_n(soft_rst_n),
        .start_Filling(start_Filling), .start_washing(start_washing),
        .start_Rinsing(start_Rinsing), .start_spining(start_spining),
        .timer_pause(timer_pause),
        .Filling_water_done(Filling_water_done), .Washing_done(Washing_done),
        .Rinsing_done(Rinsing_done), .spining_done(spining_done),
        .phase(phase), .min_left(min_left), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: active phase and number of counted cycles since entry.
    int m_phase, m_elapsed, m_done;
    bit m_fired;

    int cyc;
    int done_cnt [1:4];
    int done_cyc [1:4];
    int order [$];
    int done_hi_cycles;

    function automatic int mdur(input int p);
        case (p)
            1: return FM;
            2: return WM;
            3: return RM;
            4: return SM;
            default: return 0;
        endcase
    endfunction

    function automatic logic done_of(input int p);
        case (p)
            1: return Filling_water_done;
            2: return Washing_done;
            3: return Rinsing_done;
            4: return spining_done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_elapsed = 0; m_fired = 0; m_done = 0;
    endtask

    task automatic model_edge();
        int sel;
        if (rst) begin
            model_reset();
            return;
        end
        sel = start_spining ? 4 : start_Rinsing ? 3 : start_washing ? 2 : start_Filling ? 1 : 0;
        m_done = 0;
        if (sel != m_phase) begin
            m_phase = sel; m_elapsed = 0; m_fired = 0;
        end else if (!soft_rst_n) begin
            m_elapsed = 0; m_fired = 0;
        end else if (m_phase != 0 && !timer_pause && !m_fired) begin
            m_elapsed++;
            if (m_elapsed == mdur(m_phase) * int'(T)) begin
                m_fired = 1;
                m_done  = m_phase;
            end
        end
    endtask

    task automatic clr_rec();
        cyc = 0;
        for (int i = 1; i <= 4; i++) begin
            done_cnt[i] = 0;
            done_cyc[i] = -1;
        end
        order.delete();
        done_hi_cycles = 0;
    endtask

    task automatic set_in(input logic [3:0] st);
        {start_spining, start_Rinsing, start_washing, start_Filling} = st;
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic step();
        logic [3:0] dv, edv;
        int exp_ml;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        dv     = {spining_done, Rinsing_done, Washing_done, Filling_water_done};
        edv    = (m_done == 0) ? 4'b0000 : 4'(4'b0001 << (m_done - 1));
        exp_ml = (m_phase == 0) ? 0 : mdur(m_phase) - m_elapsed / int'(T);
        chk("phase", 32'(phase), 32'(m_phase));
        chk("min_left", 32'(min_left), 32'(exp_ml));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("done", 32'(dv), 32'(edv));
        if (dv != 4'b0000) done_hi_cycles++;
        for (int p = 1; p <= 4; p++) begin
            if (dv[p-1] === 1'b1) begin
                done_cnt[p]++;
                done_cyc[p] = cyc;
                order.push_back(p);
            end
        end
    endtask

    initial begin
        int seq [6];
        int idx;
        int busy_fall;
        logic [3:0] st;

        rst = 1'b1; soft_rst_n = 1'b1; timer_pause = 1'b0;
        set_in(4'b0000);
        model_reset();
        clr_rec();
        repeat (2) step();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_min_left", 32'(min_left), 32'd0);
        rst = 1'b0;
        step();

        // Fill timing
        clr_rec(); set_in(4'b0001);
        step();
        chk("fill_phase_c1", 32'(phase), 32'd1);
        repeat (39) step();
        chk("fill_done_cycle", 32'(done_cyc[1]), 32'd9);
        chk("fill_done_count", 32'(done_cnt[1]), 32'd1);
        set_in(4'b0000); step();

        // Overlap priority
        clr_rec(); set_in(4'b0010);
        repeat (3) step();
        set_in(4'b0110); step();
        chk("ovl_phase_c4", 32'(phase), 32'd3);
        set_in(4'b0100);
        repeat (16) step();
        chk("ovl_rinse_cycle", 32'(done_cyc[3]), 32'd12);
        chk("ovl_no_wash", 32'(done_cnt[2]), 32'd0);
        set_in(4'b0000); step();

        // Pause
        clr_rec(); set_in(4'b1000);
        for (int c = 0; c < 16; c++) begin
            timer_pause = (c >= 2 && c <= 6);
            step();
            if (cyc >= 3 && cyc <= 7) chk("pause_min_left", 32'(min_left), 32'd1);
        end
        timer_pause = 1'b0;
        chk("pause_spin_cycle", 32'(done_cyc[4]), 32'd10);
        set_in(4'b0000); step();

        // Soft reset mid-phase
        clr_rec(); set_in(4'b0010);
        for (int c = 0; c < 26; c++) begin
            soft_rst_n = (c != 7);
            step();
            if (cyc == 8) chk("soft_min_left", 32'(min_left), 32'd3);
        end
        soft_rst_n = 1'b1;
        chk("soft_wash_cycle", 32'(done_cyc[2]), 32'd20);
        chk("soft_wash_count", 32'(done_cnt[2]), 32'd1);

        // Asynchronous reset mid-phase, then restart with start still held
        set_in(4'b0000); step();
        set_in(4'b0010);
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_min_left", 32'(min_left), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'({spining_done, Rinsing_done, Washing_done, Filling_water_done}), 32'd0);
        model_reset();
        step();
        rst = 1'b0;
        repeat (15) step();
        set_in(4'b0000); step();

        // Round 2 re-entry
        clr_rec();
        for (int c = 0; c < 46; c++) begin
            set_in(c < 15 ? 4'b0010 : c < 26 ? 4'b0100 : 4'b0010);
            step();
        end
        chk("r2_wash_count", 32'(done_cnt[2]), 32'd2);
        chk("r2_wash2_cycle", 32'(done_cyc[2]), 32'd39);
        chk("r2_rinse_cycle", 32'(done_cyc[3]), 32'd24);
        set_in(4'b0000); step();

        // Closed loop with a double-wash controller
        clr_rec();
        seq = '{1, 2, 3, 2, 3, 4};
        idx = 0; busy_fall = -1;
        for (int c = 0; c < 200 && busy_fall < 0; c++) begin
            set_in(idx < 6 ? 4'(4'b0001 << (seq[idx] - 1)) : 4'b0000);
            step();
            if (idx < 6 && done_of(seq[idx]) === 1'b1) idx++;
            if (idx == 6 && done_cnt[4] > 0 && busy === 1'b0 && busy_fall < 0) busy_fall = cyc;
        end
        chk("int_pulse_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < order.size()) chk("int_order", 32'(order[i]), 32'(seq[i]));
        end
        chk("int_pulse_width", 32'(done_hi_cycles), 32'd6);
        chk("int_busy_fall", 32'(busy_fall), 32'(done_cyc[4] + 1));
        set_in(4'b0000); step();

        // Random traffic against the model
        st = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 6))
                    0: st = 4'b0000;
                    1: st = 4'b0001;
                    2: st = 4'b0010;
                    3: st = 4'b0100;
                    4: st = 4'b1000;
                    default: st = 4'($urandom_range(0, 15));
                endcase
            end
            set_in(st);
            timer_pause = ($urandom_range(0, 5) == 0);
            soft_rst_n  = ($urandom_range(0, 23) != 0);
            rst         = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; soft_rst_n = 1'b1; timer_pause = 1'b0;
        set_in(4'b0000); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
